multiplicador_seq_param: RTL and testbench
==========================================

// Module: multiplicador_seq_param
// PURPOSE
//  Parametrised shift-add sequential multiplier. Successor to the fixed 4-bit unsigned unit.
//  Multiplies two W-bit operands, unsigned or two's-complement signed, selected per operation.
//  Signed mode uses radix-2 Booth recoding. Uses a St/Done/Idle handshake and back-to-back starts.
//  Sits between operand registers and the datapath result bus; one product per W+1 cycles.
// PARAMETERS
//  W        4   operand width in bits, >= 2; product is 2*W bits
//  CNT_W    $clog2(W+1)  step-counter width (derived, not overridden)
// PORTS
//  Clk            in   1     clock; all state changes on rising edge
//  Rst            in   1     synchronous reset, active-high
//  St             in   1     start request; sampled only when Idle=1 or Done=1
//  Signed         in   1     1 = operands are two's complement; sampled with St
//  Multiplicando  in   W     multiplicand; sampled with St
//  Multiplicador  in   W     multiplier; sampled with St
//  Produto        out  2*W   product; valid while Done=1, then held until next accepted St
//  Done           out  1     one-cycle pulse: Produto valid
//  Idle           out  1     1 in IDLE state only
// BEHAVIOUR
//  Interface: one clock, Clk; reset is synchronous and active-high, Rst.
//  Reset: state=IDLE, Produto=0, Done=0, Idle=1, counter=0, accumulator=0.
//   Rst wins over every other input, including mid-operation. A partial result is discarded.
//  FSM states IDLE, RUN, DONE:
//   IDLE: Idle=1. St=1 -> load operands and mode, counter=W, go to RUN. St=0 -> stay.
//   RUN:  one step per cycle, counter-1. At counter==1 the final step executes -> DONE. St ignored.
//   DONE: Done=1 for exactly this cycle, Produto valid.
//         St=1 -> reload (back-to-back), go to RUN. St=0 -> IDLE.
//  Latency: St sampled at edge E0. Steps occur on edges E1..EW. Done=1 in the cycle after EW.
//  Unsigned step: acc={C,A[W-1:0],Q[W-1:0]}, W+1 bits on the A side.
//   If Q[0], then {C,A}=A+Mcand. Then logical right-shift the whole acc by 1.
//  Signed step: acc={A[W-1:0],Q[W-1:0],q_1}, with q_1=0 at load.
//   {Q[0],q_1}=01 -> A=A+Mcand; 10 -> A=A-Mcand; 00/11 -> no-op.
//   Then arithmetic right-shift: sign is A[W] of the W+1-bit add result, so overflow is not lost.
//  Produto = {A,Q} after the final step; registered, no combinational path from inputs.
//  Boundaries:
//   Most-negative operands: -2^(W-1) * -2^(W-1) = 2^(2W-2), correct in 2W bits.
//   Zero operand: the full W steps still run; latency is constant and never data-dependent.
//   Operand or Signed changes during RUN have no effect; values are latched at St.
//   St held high continuously gives products every W+1 cycles. IDLE is never re-entered.
// STRUCTURE
//  Shared package mult_pkg: FSM state enum (IDLE/RUN/DONE), Booth op encoding (NOP/ADD/SUB).
//  Sub-module step_counter: loadable down-counter, CNT_W bits.
//   Inputs Load/Dec/Clk/Rst; output Last (count==1).
//  Adder/subtractor and shift register stay inline in this module.
// TESTING
//  W=4 unsigned 15*15: St pulse at E0 -> Done=1 exactly 4 edges later, Produto=8'hE1 (225).
//  W=4 signed -8*-8 (4'h8,4'h8) -> Produto=8'h40. Signed -8*7 -> 8'hC8 (-56).
//   Same operands unsigned: 8*7 -> 8'h38.
//  W=4 3*0 and 0*0 -> Produto=0, Done still at E0+4 edges. Idle=0 throughout RUN.
//  St held high, 3 ops (2*3, 5*5, 15*1) -> Done pulses 5 cycles apart, 6/25/15.
//   Idle stays 0 between ops.
//  Rst asserted at E2 of an op -> next cycle Idle=1, Done=0, Produto=0.
//   A fresh 7*6 then gives 42.
//  W=8 unsigned 255*255 -> 16'hFE01 after 8 steps.
//   Signed -128*127 -> 16'hC080. St toggled during RUN -> ignored.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state codes and
// the radix-2 Booth operation selected on each step.
package mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Unsigned mode adds on Q[0]; signed mode inspects the {Q[0], q_1} pair.
  function automatic booth_op_t booth_decode(input logic signed_mode,
                                             input logic q0,
                                             input logic q_1);
    booth_op_t op;
    op = OP_NOP;
    if (!signed_mode) begin
      if (q0) op = OP_ADD;
    end else begin
      case ({q0, q_1})
        2'b01:   op = OP_ADD;
        2'b10:   op = OP_SUB;
        default: op = OP_NOP;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/step_counter.sv
// Loadable down-counter that tracks the remaining multiply steps and flags
// the final one.
module step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic             Dec,
  input  logic [CNT_W-1:0] Value,
  output logic             Last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge Clk) begin
    if (Rst)
      count <= '0;
    else if (Load)
      count <= Value;
    else if (Dec)
      count <= count - CNT_W'(1);
  end

  assign Last = (count == CNT_W'(1));

endmodule

// File: rtl/multiplicador_seq_param.sv
// W-bit sequential multiplier, unsigned shift-add or signed radix-2 Booth,
// one step per cycle with a St/Done/Idle handshake that allows back-to-back starts.
module multiplicador_seq_param
  import mult_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           St,
  input  logic           Signed,
  input  logic [W-1:0]   Multiplicando,
  input  logic [W-1:0]   Multiplicador,
  output logic [2*W-1:0] Produto,
  output logic           Done,
  output logic           Idle
);

  localparam int CNT_W = $clog2(W + 1);

  state_t    state;
  logic [W-1:0] a_reg;
  logic [W-1:0] q_reg;
  logic [W-1:0] mcand;
  logic      q_1;
  logic      sgn;
  logic      last;
  logic      accept;
  booth_op_t op;
  logic [W:0] ext_a;
  logic [W:0] ext_m;
  logic [W:0] sum;

  assign accept = St && ((state == ST_IDLE) || (state == ST_DONE));
  assign op     = booth_decode(sgn, q_reg[0], q_1);

  // The extra top bit keeps the carry (unsigned) or the true sign (signed),
  // so an overflowing add still shifts the correct bit into A.
  assign ext_a = {sgn & a_reg[W-1], a_reg};
  assign ext_m = {sgn & mcand[W-1], mcand};

  always_comb begin
    sum = ext_a;
    case (op)
      OP_ADD:  sum = ext_a + ext_m;
      OP_SUB:  sum = ext_a - ext_m;
      default: sum = ext_a;
    endcase
  end

  step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .Clk   (Clk),
    .Rst   (Rst),
    .Load  (accept),
    .Dec   (state == ST_RUN),
    .Value (CNT_W'(W)),
    .Last  (last)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= ST_IDLE;
      a_reg   <= '0;
      q_reg   <= '0;
      mcand   <= '0;
      q_1     <= 1'b0;
      sgn     <= 1'b0;
      Produto <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          a_reg <= sum[W:1];
          q_reg <= {sum[0], q_reg[W-1:1]};
          q_1   <= q_reg[0];
          if (last) begin
            Produto <= {sum, q_reg[W-1:1]};
            state   <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (St) begin
            a_reg <= '0;
            q_reg <= Multiplicador;
            mcand <= Multiplicando;
            q_1   <= 1'b0;
            sgn   <= Signed;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Done = (state == ST_DONE);
  assign Idle = (state == ST_IDLE);

endmodule

// File: tb/tb_multiplicador_seq_param.sv
// Self-checking bench for multiplicador_seq_param at W=4 and W=8: a timeline
// model of accepted starts predicts Done/Idle/Produto every cycle.
module tb_multiplicador_seq_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st_v [2];
  logic       sg_v [2];
  logic [7:0] ma   [2];
  logic [7:0] mb   [2];

  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic        done4, idle4, done8, idle8;

  int          wv [2] = '{4, 8};
  int          edge_n = 0;
  bit          armed = 1'b0;
  bit          has_op [2] = '{1'b0, 1'b0};
  int          done_edge [2] = '{0, 0};
  logic [15:0] pend_prod [2];
  logic [15:0] prod_now  [2];

  int n_vec = 0;
  int n_err = 0;

  multiplicador_seq_param #(.W(4)) u_dut4 (
    .Clk           (clk),
    .Rst           (rst),
    .St            (st_v[0]),
    .Signed        (sg_v[0]),
    .Multiplicando (ma[0][3:0]),
    .Multiplicador (mb[0][3:0]),
    .Produto       (prod4),
    .Done          (done4),
    .Idle          (idle4)
  );

  multiplicador_seq_param #(.W(8)) u_dut8 (
    .Clk           (clk),
    .Rst           (rst),
    .St            (st_v[1]),
    .Signed        (sg_v[1]),
    .Multiplicando (ma[1]),
    .Multiplicador (mb[1]),
    .Produto       (prod8),
    .Done          (done8),
    .Idle          (idle8)
  );

  // Reference product: plain integer arithmetic truncated to 2*w bits.
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a,
                                          input logic [7:0] b, input logic s);
    longint x, y, p;
    x = longint'(a) & ((longint'(1) << w) - 1);
    y = longint'(b) & ((longint'(1) << w) - 1);
    if (s) begin
      if (x >= (longint'(1) << (w - 1))) x -= (longint'(1) << w);
      if (y >= (longint'(1) << (w - 1))) y -= (longint'(1) << w);
    end
    p = x * y;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic doneOf(input int i);
    return (i == 0) ? done4 : done8;
  endfunction

  function automatic logic idleOf(input int i);
    return (i == 0) ? idle4 : idle8;
  endfunction

  function automatic logic [15:0] prodOf(input int i);
    return (i == 0) ? {8'h00, prod4} : prod8;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input logic s, input logic sg,
                               input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    st_v[i] = s;
    sg_v[i] = sg;
    ma[i]   = a;
    mb[i]   = b;
  endtask

  // Counts falling edges until Done; Idle must stay low the whole way.
  task automatic waitDone(input int i, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      checkOutput("busy_idle", 16'(idleOf(i)), 16'd0);
    end while (!doneOf(i) && cycles < 40);
  endtask

  task automatic runOp(input int i, input logic sg, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] expected,
                       input string name);
    int c;
    applyStimulus(i, 1'b1, sg, a, b);
    applyStimulus(i, 1'b0, sg, a, b);
    waitDone(i, c);
    checkOutput({name, "_lat"}, 16'(c), 16'(wv[i]));
    checkOutput(name, prodOf(i), expected);
  endtask

  // Model: an accepted start at edge n completes at edge n+W; starts are
  // refused while an earlier operation is still short of its completion edge.
  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        has_op[i]   = 1'b0;
        prod_now[i] = 16'h0;
        armed       = 1'b1;
      end else begin
        if (has_op[i] && edge_n == done_edge[i])
          prod_now[i] = pend_prod[i];
        if (st_v[i] && !(has_op[i] && (edge_n - 1) < done_edge[i])) begin
          has_op[i]    = 1'b1;
          done_edge[i] = edge_n + wv[i];
          pend_prod[i] = ref_mul(wv[i], ma[i], mb[i], sg_v[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    bit running, exp_done, exp_idle;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        running  = has_op[i] && (edge_n < done_edge[i]);
        exp_done = has_op[i] && (edge_n == done_edge[i]);
        exp_idle = !(has_op[i] && (edge_n <= done_edge[i]));
        checkOutput((i == 0) ? "done4" : "done8", 16'(doneOf(i)), 16'(exp_done));
        checkOutput((i == 0) ? "idle4" : "idle8", 16'(idleOf(i)), 16'(exp_idle));
        if (!running)
          checkOutput((i == 0) ? "prod4" : "prod8", prodOf(i), prod_now[i]);
      end
    end
  end

  initial begin
    int c;
    rst   = 1'b1;
    st_v  = '{1'b0, 1'b0};
    sg_v  = '{1'b0, 1'b0};
    ma    = '{8'h0, 8'h0};
    mb    = '{8'h0, 8'h0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_idle4", 16'(idle4), 16'd1);
    checkOutput("rst_done4", 16'(done4), 16'd0);
    checkOutput("rst_prod4", {8'h00, prod4}, 16'h0);
    checkOutput("rst_idle8", 16'(idle8), 16'd1);
    checkOutput("rst_prod8", prod8, 16'h0);

    runOp(0, 1'b0, 8'd15, 8'd15, 16'h00E1, "u15x15");
    runOp(0, 1'b1, 8'h8,  8'h8,  16'h0040, "s-8x-8");
    runOp(0, 1'b1, 8'h8,  8'h7,  16'h00C8, "s-8x7");
    runOp(0, 1'b0, 8'h8,  8'h7,  16'h0038, "u8x7");
    runOp(0, 1'b0, 8'd3,  8'd0,  16'h0000, "u3x0");
    runOp(0, 1'b0, 8'd0,  8'd0,  16'h0000, "u0x0");

    // St held high across three operations
    applyStimulus(0, 1'b1, 1'b0, 8'd2, 8'd3);
    @(negedge clk);
    ma[0] = 8'($urandom);
    mb[0] = 8'($urandom);
    sg_v[0] = 1'b1;
    waitDone(0, c);
    checkOutput("b2b_lat1", 16'(c), 16'd4);
    checkOutput("b2b_p1", {8'h00, prod4}, 16'd6);
    sg_v[0] = 1'b0; ma[0] = 8'd5; mb[0] = 8'd5;
    waitDone(0, c);
    checkOutput("b2b_gap1", 16'(c), 16'd5);
    checkOutput("b2b_p2", {8'h00, prod4}, 16'd25);
    ma[0] = 8'd15; mb[0] = 8'd1;
    @(negedge clk);
    st_v[0] = 1'b0;
    waitDone(0, c);
    checkOutput("b2b_gap2", 16'(c + 1), 16'd5);
    checkOutput("b2b_p3", {8'h00, prod4}, 16'd15);

    // Reset sampled on the third edge of an operation
    applyStimulus(0, 1'b1, 1'b0, 8'd9, 8'd9);
    applyStimulus(0, 1'b0, 1'b0, 8'd9, 8'd9);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_idle", 16'(idle4), 16'd1);
    checkOutput("mid_rst_done", 16'(done4), 16'd0);
    checkOutput("mid_rst_prod", {8'h00, prod4}, 16'h0);
    rst = 1'b0;
    runOp(0, 1'b0, 8'd7, 8'd6, 16'd42, "u7x6");

    runOp(1, 1'b0, 8'd255, 8'd255, 16'hFE01, "u255x255");

    // Signed W=8 with St and operands churning during RUN
    applyStimulus(1, 1'b1, 1'b1, 8'h80, 8'h7F);
    applyStimulus(1, 1'b0, 1'b1, 8'h80, 8'h7F);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      st_v[1] = (k % 2 == 1) && (k < 6);
      sg_v[1] = 1'($urandom_range(0, 1));
      ma[1]   = 8'($urandom);
      mb[1]   = 8'($urandom);
    end
    @(negedge clk);
    checkOutput("tog_notdone", 16'(done8), 16'd0);
    @(negedge clk);
    checkOutput("tog_done", 16'(done8), 16'd1);
    checkOutput("s-128x127", prod8, 16'hC080);

    // Random traffic on both widths, including occasional resets
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        st_v[i] = ($urandom_range(0, 3) != 0);
        sg_v[i] = 1'($urandom_range(0, 1));
        ma[i]   = 8'($urandom);
        mb[i]   = 8'($urandom);
      end
      rst = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    st_v = '{1'b0, 1'b0};
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
